// File: rtl/clk_sel_pkg.sv
// Shared types and helpers for the divided-clock select detector.
// Holds the default widths, the FSM state type and the one-hot index helper.
package clk_sel_pkg;

    localparam int SEL_W = 4;
    localparam int CNT_W = 2**SEL_W + 1;
    localparam int IDX_W = 6;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        LOCKED
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } onehot_t;

    // valid only when exactly one bit is set; idx is then that bit's position
    function automatic onehot_t onehot_to_idx(input logic [63:0] v);
        onehot_t r;
        int      n;
        r = '0;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (v[i]) begin
                n     = n + 1;
                r.idx = IDX_W'(i);
            end
        end
        r.valid = (n == 1);
        return r;
    endfunction

endpackage

// File: rtl/clk_sel_detect_if.sv
// Bus between a divided-clock source and the select detector.
// master drives div_clk and observes the recovered code; slave is the detector.
interface clk_sel_detect_if #(
    parameter int SEL_W = clk_sel_pkg::SEL_W
);

    logic             div_clk;
    logic [SEL_W-1:0] sel_out;
    logic             meas_valid;
    logic             locked;
    logic             err;

    modport master (
        output div_clk,
        input  sel_out,
        input  meas_valid,
        input  locked,
        input  err
    );

    modport slave (
        input  div_clk,
        output sel_out,
        output meas_valid,
        output locked,
        output err
    );

endinterface

// File: rtl/clk_sel_pow2_decode.sv
// Combinational power-of-two interval decoder: meas -> {valid, log2 code}.
// With CLK_SEL_DETECT_FULL_PERIOD_EN the interval is a full period, so code = log2 - 1.
module clk_sel_pow2_decode #(
    parameter int SEL_W = clk_sel_pkg::SEL_W,
    parameter int CNT_W = 2**SEL_W + 1
) (
    input  logic [CNT_W-1:0] meas,
    output logic             valid,
    output logic [SEL_W-1:0] code
);
    import clk_sel_pkg::*;

    localparam int MAX_IDX = 2**SEL_W - 1;

    onehot_t oh;

    always_comb begin
        oh = onehot_to_idx(64'(meas));
`ifdef CLK_SEL_DETECT_FULL_PERIOD_EN
        // meas == 1 cannot be a full period of any tap
        valid = oh.valid && (oh.idx != '0) && (int'(oh.idx) <= MAX_IDX + 1);
        code  = SEL_W'(oh.idx - IDX_W'(1));
`else
        valid = oh.valid && (int'(oh.idx) <= MAX_IDX);
        code  = SEL_W'(oh.idx);
`endif
    end

endmodule

// File: rtl/clk_sel_detect.sv
// Recovers the power-of-two divider select code from a divided clock and tracks lock.
// Optional build macro CLK_SEL_DETECT_FULL_PERIOD_EN: measure rising-to-rising only.
module clk_sel_detect #(
    parameter int SEL_W    = clk_sel_pkg::SEL_W,
    parameter int CNT_W    = 2**SEL_W + 1,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    clk_sel_detect_if.slave  bus
);
    import clk_sel_pkg::*;

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);

    logic               s1, s2, s3;
    logic               div_edge;
    logic               cnt_sat;
    logic [CNT_W-1:0]   cnt;
    logic               code_vld;
    logic [SEL_W-1:0]   code;
    logic [SEL_W-1:0]   sel_out;
    logic [MATCH_W-1:0] match_cnt;
    logic [MATCH_W-1:0] next_match;
    logic               meas_valid;
    logic               locked;
    logic               err;
    state_t             state;

`ifdef CLK_SEL_DETECT_FULL_PERIOD_EN
    assign div_edge = s2 & ~s3;
`else
    assign div_edge = s2 ^ s3;
`endif

    assign cnt_sat = &cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            s3  <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= bus.div_clk;
            s2 <= s1;
            s3 <= s2;
            if (div_edge) begin
                cnt <= CNT_W'(1);
            end else if (!cnt_sat) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Decoding cnt directly in the edge cycle keeps meas_valid at 3 clk after the transition
    clk_sel_pow2_decode #(
        .SEL_W (SEL_W),
        .CNT_W (CNT_W)
    ) u_decode (
        .meas  (cnt),
        .valid (code_vld),
        .code  (code)
    );

    assign next_match = (code == sel_out) ? match_cnt + MATCH_W'(1) : MATCH_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel_out    <= '0;
            match_cnt  <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // the interval closed by the first edge has an unknown start
                    if (div_edge) begin
                        state <= MEASURE;
                    end
                end
                default: begin
                    if (div_edge) begin
                        meas_valid <= 1'b1;
                        if (!code_vld) begin
                            err       <= 1'b1;
                            locked    <= 1'b0;
                            match_cnt <= '0;
                            state     <= MEASURE;
                        end else if (!(state == LOCKED && code == sel_out)) begin
                            sel_out   <= code;
                            match_cnt <= next_match;
                            if (next_match == MATCH_W'(LOCK_CNT)) begin
                                locked <= 1'b1;
                                state  <= LOCKED;
                            end else begin
                                locked <= 1'b0;
                                state  <= MEASURE;
                            end
                        end
                    end else if (cnt_sat) begin
                        locked    <= 1'b0;
                        match_cnt <= '0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.sel_out    = sel_out;
    assign bus.meas_valid = meas_valid;
    assign bus.locked     = locked;
    assign bus.err        = err;

endmodule

// File: tb/tb_clk_sel_detect.sv
// Directed bench for clk_sel_detect in a reduced configuration (SEL_W=3, CNT_W=9)
// so that timeout and slowest-tap scenarios stay short; step t is sampled 1 unit after a posedge.
module tb_clk_sel_detect;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;
    int   mv_n, mv_first, lock_rise, lock_fall, err_first;

    clk_sel_detect_if #(.SEL_W(3)) bus ();

    clk_sel_detect #(
        .SEL_W    (3),
        .CNT_W    (9),
        .LOCK_CNT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n       = 1'b0;
        bus.div_clk = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Toggle div_clk every 'half' steps, ntog times, then run 3 more steps to see the last result
    task automatic run_stream(input int half, input int ntog);
        int   steps;
        logic prev_lk;
        steps     = (ntog - 1) * half + 4;
        mv_n      = 0;
        mv_first  = -1;
        lock_rise = -1;
        lock_fall = -1;
        err_first = -1;
        prev_lk   = bus.locked;
        for (int t = 0; t < steps; t++) begin
            @(posedge clk);
            #1;
            if (bus.meas_valid) begin
                mv_n++;
                if (mv_first < 0) mv_first = t;
            end
            if (bus.locked && !prev_lk && lock_rise < 0) lock_rise = t;
            if (!bus.locked && prev_lk && lock_fall < 0) lock_fall = t;
            if (bus.err && err_first < 0) err_first = t;
            prev_lk = bus.locked;
            if ((t % half == 0) && (t <= (ntog - 1) * half)) bus.div_clk = ~bus.div_clk;
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b1;
        bus.div_clk = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.sel_out !== 3'd0) begin n_fail++; $display("FAIL reset_sel_out: got %0d want 0", bus.sel_out); end
        n_cmp++; if (bus.meas_valid !== 1'b0) begin n_fail++; $display("FAIL reset_meas_valid: got %b want 0", bus.meas_valid); end
        n_cmp++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", bus.locked); end
        n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_sel3();
        do_reset();
        run_stream(8, 6);
        n_cmp++; if (mv_first !== 11) begin n_fail++; $display("FAIL sel3_first_valid: got %0d want 11", mv_first); end
        n_cmp++; if (mv_n !== 5) begin n_fail++; $display("FAIL sel3_valid_count: got %0d want 5", mv_n); end
        n_cmp++; if (lock_rise !== 35) begin n_fail++; $display("FAIL sel3_lock_step: got %0d want 35", lock_rise); end
        n_cmp++; if (bus.sel_out !== 3'd3) begin n_fail++; $display("FAIL sel3_sel_out: got %0d want 3", bus.sel_out); end
        n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL sel3_err: got %b want 0", bus.err); end
    endtask

    task automatic test_sel0();
        do_reset();
        run_stream(1, 8);
        n_cmp++; if (mv_n !== 7) begin n_fail++; $display("FAIL sel0_valid_count: got %0d want 7", mv_n); end
        n_cmp++; if (lock_rise !== 7) begin n_fail++; $display("FAIL sel0_lock_step: got %0d want 7", lock_rise); end
        n_cmp++; if (bus.sel_out !== 3'd0) begin n_fail++; $display("FAIL sel0_sel_out: got %0d want 0", bus.sel_out); end
        n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL sel0_err: got %b want 0", bus.err); end
    endtask

    task automatic test_switch();
        do_reset();
        run_stream(32, 6);
        n_cmp++; if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL switch_lock5: got %b want 1", bus.locked); end
        n_cmp++; if (bus.sel_out !== 3'd5) begin n_fail++; $display("FAIL switch_sel5: got %0d want 5", bus.sel_out); end
        run_stream(4, 6);
        n_cmp++; if (lock_fall !== 3) begin n_fail++; $display("FAIL switch_lock_drop: got %0d want 3", lock_fall); end
        n_cmp++; if (lock_rise !== 15) begin n_fail++; $display("FAIL switch_relock: got %0d want 15", lock_rise); end
        n_cmp++; if (bus.sel_out !== 3'd2) begin n_fail++; $display("FAIL switch_sel2: got %0d want 2", bus.sel_out); end
        n_cmp++; if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL switch_locked_end: got %b want 1", bus.locked); end
    endtask

    task automatic test_bad_interval();
        do_reset();
        run_stream(6, 2);
        n_cmp++; if (err_first !== 9) begin n_fail++; $display("FAIL bad_err_step: got %0d want 9", err_first); end
        n_cmp++; if (mv_n !== 1) begin n_fail++; $display("FAIL bad_valid_count: got %0d want 1", mv_n); end
        n_cmp++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL bad_locked: got %b want 0", bus.locked); end
        run_stream(2, 8);
        n_cmp++; if (lock_rise !== 11) begin n_fail++; $display("FAIL bad_relock: got %0d want 11", lock_rise); end
        n_cmp++; if (bus.sel_out !== 3'd1) begin n_fail++; $display("FAIL bad_sel1: got %0d want 1", bus.sel_out); end
        n_cmp++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL bad_err_sticky: got %b want 1", bus.err); end
    endtask

    task automatic test_range();
        do_reset();
        run_stream(128, 3);
        n_cmp++; if (bus.sel_out !== 3'd7) begin n_fail++; $display("FAIL range_sel7: got %0d want 7", bus.sel_out); end
        n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL range_err_max_tap: got %b want 0", bus.err); end
        run_stream(256, 2);
        n_cmp++; if (err_first !== 259) begin n_fail++; $display("FAIL range_err_step: got %0d want 259", err_first); end
        n_cmp++; if (bus.sel_out !== 3'd2) begin n_fail++; $display("FAIL range_sel_hold: got %0d want 2", bus.sel_out); end
        n_cmp++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL range_locked: got %b want 0", bus.locked); end
    endtask

    task automatic test_timeout();
        int k_drop;
        do_reset();
        run_stream(4, 6);
        n_cmp++; if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL timeout_pre_lock: got %b want 1", bus.locked); end
        k_drop = -1;
        for (int k = 1; k <= 600; k++) begin
            @(posedge clk);
            #1;
            if (!bus.locked) begin
                k_drop = k;
                break;
            end
        end
        n_cmp++; if (k_drop !== 511) begin n_fail++; $display("FAIL timeout_drop_step: got %0d want 511", k_drop); end
        run_stream(4, 2);
        n_cmp++; if (mv_n !== 1) begin n_fail++; $display("FAIL timeout_valid_count: got %0d want 1", mv_n); end
        n_cmp++; if (mv_first !== 7) begin n_fail++; $display("FAIL timeout_first_valid: got %0d want 7", mv_first); end
        n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL timeout_err: got %b want 0", bus.err); end
    endtask

    task automatic test_async_reset();
        do_reset();
        run_stream(128, 6);
        n_cmp++; if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL arst_pre_lock: got %b want 1", bus.locked); end
        n_cmp++; if (bus.sel_out !== 3'd7) begin n_fail++; $display("FAIL arst_pre_sel: got %0d want 7", bus.sel_out); end
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.sel_out !== 3'd0) begin n_fail++; $display("FAIL arst_sel_out: got %0d want 0", bus.sel_out); end
        n_cmp++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL arst_locked: got %b want 0", bus.locked); end
        n_cmp++; if (bus.meas_valid !== 1'b0) begin n_fail++; $display("FAIL arst_meas_valid: got %b want 0", bus.meas_valid); end
        n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL arst_err: got %b want 0", bus.err); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_stream(128, 6);
        n_cmp++; if (lock_rise !== 515) begin n_fail++; $display("FAIL arst_relock: got %0d want 515", lock_rise); end
        n_cmp++; if (mv_n !== 5) begin n_fail++; $display("FAIL arst_valid_count: got %0d want 5", mv_n); end
        n_cmp++; if (bus.sel_out !== 3'd7) begin n_fail++; $display("FAIL arst_sel7: got %0d want 7", bus.sel_out); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_sel3();
        test_sel0();
        test_switch();
        test_bad_interval();
        test_range();
        test_timeout();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
